pipe_stage_skid: RTL and testbench

// - Parametrised pipeline stage register with valid/ready flow control.
// - Successor to the fixed-field stage latches (IF/ID/EX/MEM); it is one

---
 rtl/pipe_stage_skid.sv | 136 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer; in_ready is registered.
// Optional perf counters (stall_cnt, flush_cnt) are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_skid #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int unsigned      CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state_r;
  logic             out_valid_r;
  logic             in_ready_r;
  logic [WIDTH-1:0] main_r;
  logic [WIDTH-1:0] skid_r;
  logic             acc_s;
  logic             take_s;

  assign acc_s     = in_valid & in_ready_r;
  assign take_s    = out_valid_r & out_ready;
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = main_r;

  // Stage FSM: state, registered handshake outputs and the two data slots.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_EMPTY;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      main_r      <= RESET_VAL;
      skid_r      <= RESET_VAL;
    end else if (flush) begin
      // Squash held entries; data slots keep their contents.
      state_r     <= ST_EMPTY;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (acc_s) begin
            main_r      <= in_data;
            state_r     <= ST_BUSY;
            out_valid_r <= 1'b1;
            in_ready_r  <= 1'b1;
          end else begin
            state_r     <= ST_EMPTY;
          end
        end
        ST_BUSY: begin
          if (acc_s && take_s) begin
            main_r      <= in_data;
          end else if (acc_s) begin
            // Downstream stalled: park the new entry and drop ready next cycle.
            skid_r      <= in_data;
            state_r     <= ST_FULL;
            in_ready_r  <= 1'b0;
          end else if (take_s) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
          end else begin
            state_r     <= ST_BUSY;
          end
        end
        ST_FULL: begin
          if (take_s) begin
            main_r      <= skid_r;
            state_r     <= ST_BUSY;
            in_ready_r  <= 1'b1;
          end else begin
            state_r     <= ST_FULL;
          end
        end
        default: begin
          state_r     <= ST_EMPTY;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;

  // Saturating counters for downstream stalls and flushes that squash live entries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (out_valid_r && !out_ready && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush && (state_r != ST_EMPTY) && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end
`else
  // Counters absent; CNT_W stays in the parameter list so both builds share one interface.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: vector table, async-reset sequence and a scoreboarded random run.
module tb_pipe_stage_skid;

  localparam int unsigned      WIDTH = 32;
  localparam logic [31:0]      RVAL  = 32'h0000_5A5A;
  localparam int unsigned      CW    = 4;

  logic             clk;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [CW-1:0]    stall_cnt;
  logic [CW-1:0]    flush_cnt;
`endif

  int n_total = 0;
  int n_pass  = 0;

  pipe_stage_skid #(.WIDTH(WIDTH), .RESET_VAL(RVAL), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        r;
    logic        f;
    logic        eov;
    logic        eir;
    logic [31:0] eod;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic v, input logic [31:0] d, input logic r, input logic f,
                              input logic eov, input logic eir, input logic [31:0] eod);
    vec_t t;
    t.v = v; t.d = d; t.r = r; t.f = f; t.eov = eov; t.eir = eir; t.eod = eod;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic f);
    in_valid = v; in_data = d; out_ready = r; flush = f;
    @(posedge clk);
    #1;
  endtask

  int unsigned q[$];
  int unsigned seq;
  int unsigned exp_v;
  logic        prev_stall;
  logic [31:0] prev_data;
  logic        acc_b;
  logic        take_b;

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_in_ready",  {31'd0, in_ready},  32'd1);
    check("reset_out_data",  out_data, RVAL);
    reset = 1'b0;

    // streaming
    vecs.push_back(mk(1'b1, 32'h1,  1'b1, 1'b0, 1'b1, 1'b1, 32'h1));
    vecs.push_back(mk(1'b1, 32'h2,  1'b1, 1'b0, 1'b1, 1'b1, 32'h2));
    vecs.push_back(mk(1'b1, 32'h3,  1'b1, 1'b0, 1'b1, 1'b1, 32'h3));
    vecs.push_back(mk(1'b1, 32'h4,  1'b1, 1'b0, 1'b1, 1'b1, 32'h4));
    vecs.push_back(mk(1'b0, 32'h9,  1'b1, 1'b0, 1'b0, 1'b1, 32'h4));
    vecs.push_back(mk(1'b0, 32'h9,  1'b0, 1'b0, 1'b0, 1'b1, 32'h4));
    // back-pressure into skid, then release
    vecs.push_back(mk(1'b1, 32'hA,  1'b0, 1'b0, 1'b1, 1'b1, 32'hA));
    vecs.push_back(mk(1'b1, 32'hB,  1'b0, 1'b0, 1'b1, 1'b0, 32'hA));
    vecs.push_back(mk(1'b1, 32'hD,  1'b0, 1'b0, 1'b1, 1'b0, 32'hA));
    vecs.push_back(mk(1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'hB));
    vecs.push_back(mk(1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 32'hB));
    // flush while FULL with 0xC offered
    vecs.push_back(mk(1'b1, 32'hE,  1'b0, 1'b0, 1'b1, 1'b1, 32'hE));
    vecs.push_back(mk(1'b1, 32'hF,  1'b0, 1'b0, 1'b1, 1'b0, 32'hE));
    vecs.push_back(mk(1'b1, 32'hC,  1'b0, 1'b1, 1'b0, 1'b1, 32'hE));
    vecs.push_back(mk(1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 32'hE));
    // flush while BUSY discards a same-cycle accept
    vecs.push_back(mk(1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11));
    vecs.push_back(mk(1'b1, 32'h12, 1'b0, 1'b1, 1'b0, 1'b1, 32'h11));
    vecs.push_back(mk(1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 32'h11));
    // BUSY accept+take, hold, drain
    vecs.push_back(mk(1'b1, 32'h21, 1'b1, 1'b0, 1'b1, 1'b1, 32'h21));
    vecs.push_back(mk(1'b1, 32'h22, 1'b1, 1'b0, 1'b1, 1'b1, 32'h22));
    vecs.push_back(mk(1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 32'h22));
    vecs.push_back(mk(1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 32'h22));
    // flush with a take in the same cycle completes the take, leaves EMPTY
    vecs.push_back(mk(1'b1, 32'h31, 1'b1, 1'b0, 1'b1, 1'b1, 32'h31));
    vecs.push_back(mk(1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b1, 32'h31));

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].f);
      check($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].eov});
      check($sformatf("vec%0d_in_ready", i),  {31'd0, in_ready},  {31'd0, vecs[i].eir});
      check($sformatf("vec%0d_out_data", i),  out_data, vecs[i].eod);
    end

    // asynchronous reset between edges while BUSY
    drive(1'b1, 32'h77, 1'b0, 1'b0);
    check("busy_before_reset", out_data, 32'h77);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_out_data",  out_data, RVAL);
    check("async_rst_in_ready",  {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;

`ifdef PIPE_STAGE_PERF_EN
    check("perf_reset_stall", {28'd0, stall_cnt}, 32'd0);
    drive(1'b1, 32'h55, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b0, 32'h0, 1'b0, 1'b0);
    check("stall_cnt_sat", {28'd0, stall_cnt}, 32'd15);
    check("flush_cnt_zero", {28'd0, flush_cnt}, 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check("flush_cnt_one", {28'd0, flush_cnt}, 32'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check("flush_cnt_empty", {28'd0, flush_cnt}, 32'd1);
`endif

    // random traffic against a scoreboard
    seq = 32'd100;
    prev_stall = 1'b0;
    prev_data  = 32'h0;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(1, 0) == 1);
      out_ready = ($urandom_range(1, 0) == 1);
      in_data   = seq;
      flush     = 1'b0;
      if (prev_stall) begin
        check("stall_valid_stable", {31'd0, out_valid}, 32'd1);
        check("stall_data_stable", out_data, prev_data);
      end
      acc_b  = in_valid & in_ready;
      take_b = out_valid & out_ready;
      if (take_b) begin
        if (q.size() == 0) check("rand_spurious_out", out_data, 32'hFFFF_FFFF);
        else begin
          exp_v = q.pop_front();
          check("rand_order", out_data, exp_v);
        end
      end
      if (acc_b) begin
        q.push_back(seq);
        seq++;
      end
      prev_stall = out_valid & ~out_ready;
      prev_data  = out_data;
      @(posedge clk);
      #1;
    end

    // bounded drain
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) begin
        if (q.size() == 0) check("drain_spurious_out", out_data, 32'hFFFF_FFFF);
        else begin
          exp_v = q.pop_front();
          check("drain_order", out_data, exp_v);
        end
      end
      @(posedge clk);
      #1;
    end
    check("scoreboard_empty", q.size(), 32'd0);
    check("drained_out_valid", {31'd0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
